hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: REG_ADDR_WIDTH, 5, register-index width.
REQ-002 Parameter: MAX_WAIT, 255, tolerated consecutive mem_busy cycles before fault.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rs1_d, rs2_d  input  REG_ADDR_WIDTH  decode-stage source registers.
REQ-006 Port: rs1_e, rs2_e  input  REG_ADDR_WIDTH  execute-stage source registers.
REQ-007 Port: rd_e, rd_m, rd_w  input  REG_ADDR_WIDTH  destination registers in E, M and W.
REQ-008 Port: reg_write_m, reg_write_w  input  1  destination write enables in M and W.
REQ-009 Port: mem_read_e  input  1  execute-stage instruction is a load.
REQ-010 Port: pc_src_e  input  1  taken branch or jump resolved in E.
REQ-011 Port: mem_busy  input  1  data memory not ready.
REQ-012 Port: forward_a_e, forward_b_e  output  2  operand-mux selects for ALU A and B.
REQ-013 Port: stall_f, stall_d, stall_e, stall_m, stall_w  output  1  per-stage hold enables.
REQ-014 Port: flush_d, flush_e  output  1  D/E pipeline-register clears.
REQ-015 Port: mem_timeout  output  1  sticky memory-wait fault flag.

Function
REQ-016 The forward encoding SHALL be: 2'b00 register file, 2'b01 W result, 2'b10 M ALU result; 2'b11 is never driven.
REQ-017 forward_a_e SHALL be:
  - 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e;
  - else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e;
  - else 00.
  forward_b_e SHALL use the same rules with rs2_e. Both are combinational with zero latency. M has priority over W.
REQ-018 Load-use hazard SHALL be lu = mem_read_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
REQ-019 The FSM SHALL have states RUN, MEM_WAIT and FAULT, plus a wait counter wait_cnt sized $clog2(MAX_WAIT+1).
REQ-020 With mem_busy=0 in RUN or MEM_WAIT, outputs SHALL be:
  - stall_f = stall_d = lu && !pc_src_e;
  - flush_d = pc_src_e;
  - flush_e = lu || pc_src_e;
  - stall_e, stall_m, stall_w = 0.
  Branch has priority over load-use.
REQ-021 With mem_busy=1 in RUN or MEM_WAIT, all stall_* SHALL be 1 and flush_* SHALL be 0. Forwarding continues.
REQ-022 Transitions:
  - RUN with mem_busy -> MEM_WAIT, wait_cnt<=1.
  - MEM_WAIT with mem_busy and wait_cnt<MAX_WAIT -> wait_cnt+1.
  - MEM_WAIT with mem_busy and wait_cnt==MAX_WAIT -> FAULT.
  - MEM_WAIT with !mem_busy -> RUN, wait_cnt<=0.
REQ-023 Boundary: MAX_WAIT consecutive busy cycles SHALL NOT fault. MAX_WAIT+1 consecutive busy cycles SHALL enter FAULT at the end of cycle MAX_WAIT+1.
REQ-024 In FAULT, all stall_* SHALL be 1, flush_* 0 and mem_timeout 1, regardless of inputs, until reset. mem_timeout SHALL be 0 in every other state.

Reset
REQ-025 rst SHALL dominate all inputs. The next state SHALL be RUN with wait_cnt=0, from any state including mid-MEM_WAIT and FAULT.
REQ-026 While rst=1, outputs SHALL be: stall_*=0, flush_d=flush_e=1, forward_*=00, mem_timeout=0.

Configuration
REQ-027 With macro HAZARD_PERF_EN defined, the block SHALL add two outputs:
  - stall_cycles[31:0]: counts cycles with stall_d=1;
  - flush_cycles[31:0]: counts cycles with flush_e=1.
  Both are cleared by rst and wrap from 2^32-1 to 0. Reset cycles SHALL NOT count.
REQ-028 Without HAZARD_PERF_EN, those ports and counters SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-029 Package hazard_pkg SHALL hold:
  - fwd_sel_t enum FWD_RF, FWD_WB, FWD_MEM;
  - hz_state_t enum RUN, MEM_WAIT, FAULT.
REQ-030 The per-operand comparator SHALL be sub-module fwd_select, instantiated twice (operands A and B).

Verification
REQ-031 Forwarding: rs1_e=5, rd_m=rd_w=5, both writes set -> forward_a_e=10. Then reg_write_m=0 -> 01. Then rd_m=rd_w=0 -> 00.
REQ-032 Load-use: mem_read_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0 for one cycle. Next cycle, with mem_read_e=0, all are 0.
REQ-033 Branch with load-use: same as REQ-032 plus pc_src_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
REQ-034 Timeout at MAX_WAIT=255:
  - 255 busy cycles -> stalls 1 throughout, mem_timeout 0, then RUN.
  - 256 busy cycles -> mem_timeout=1 from cycle 257; it stays 1 after busy drops and clears only on rst.
REQ-035 Reset mid-wait: rst in the 10th busy cycle -> RUN next cycle. A following 255-cycle busy burst SHALL NOT fault.
REQ-036 HAZARD_PERF_EN: 3 isolated load-use events plus 2 taken branches -> stall_cycles=3, flush_cycles=5.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding-select and hazard-FSM state encodings.
package hazard_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, FAULT = 2'b10} hz_state_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: per-operand bypass select, M stage result preferred over W.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_m,
    input  logic                      reg_write_w,
    output logic [1:0]                sel
);
    fwd_sel_t s;
    always_comb begin
        s = (reg_write_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
            (reg_write_w && rd_w != '0 && rd_w == rs) ? FWD_WB : FWD_RF;
        sel = s;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline forwarding, load-use/branch stall-flush and memory-wait watchdog.
// Optional HAZARD_PERF_EN adds stall_cycles/flush_cycles event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_WAIT       = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_m,
    input  logic                      reg_write_w,
    input  logic                      mem_read_e,
    input  logic                      pc_src_e,
    input  logic                      mem_busy,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      stall_w,
    output logic                      flush_d,
    output logic                      flush_e,
`ifdef HAZARD_PERF_EN
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_cycles,
`endif
    output logic                      mem_timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    hz_state_t         state;
    logic [CW-1:0]     wait_cnt;
    logic [1:0]        fa, fb;
    logic              lu, hold;

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs(rs1_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .sel(fa)
    );
    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .sel(fb)
    );

    // A fault or a busy memory freezes the whole pipe; reset overrides everything.
    always_comb begin
        lu          = mem_read_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
        hold        = state == FAULT || mem_busy;
        forward_a_e = rst ? FWD_RF : fa;
        forward_b_e = rst ? FWD_RF : fb;
        stall_f     = rst ? 1'b0 : hold ? 1'b1 : lu && !pc_src_e;
        stall_d     = stall_f;
        stall_e     = !rst && hold;
        stall_m     = stall_e;
        stall_w     = stall_e;
        flush_d     = rst ? 1'b1 : hold ? 1'b0 : pc_src_e;
        flush_e     = rst ? 1'b1 : hold ? 1'b0 : lu || pc_src_e;
        mem_timeout = !rst && state == FAULT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: if (mem_busy) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= CW'(1);
                end
                MEM_WAIT: if (!mem_busy) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == MAX_CNT) begin
                    state    <= FAULT;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
                FAULT: state <= FAULT;
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(stall_d);
            flush_cycles <= flush_cycles + 32'(flush_e);
        end
    end
`endif
endmodule
